// File: rtl/font_rom_arbiter_if.sv
// Client-side bundle of the font ROM arbiter: pixel read path and two background clients.
// Requests and addresses flow toward the arbiter; grants, valids and data flow back.
interface font_rom_arbiter_if;
  logic        px_req;
  logic [10:0] px_addr;
  logic        px_valid;
  logic        px_miss;
  logic [7:0]  px_data;
  logic [1:0]  bg_req;
  logic [10:0] bg_addr0;
  logic [10:0] bg_addr1;
  logic [1:0]  bg_gnt;
  logic [1:0]  bg_valid;
  logic [7:0]  bg_data;

  modport master (
    output px_req, px_addr, bg_req, bg_addr0, bg_addr1,
    input  px_valid, px_miss, px_data, bg_gnt, bg_valid, bg_data
  );

  modport slave (
    input  px_req, px_addr, bg_req, bg_addr0, bg_addr1,
    output px_valid, px_miss, px_data, bg_gnt, bg_valid, bg_data
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: pixel path first, round-robin background clients, starvation pre-emption.
// One read per cycle, data 1 cycle after grant; no stalls, losing clients just retry (gnt same cycle).
module font_rom_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int MISS_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  font_rom_arbiter_if.slave bus,
  output logic [10:0]       rom_addr,
  input  logic [7:0]        rom_data,
  output logic [MISS_W-1:0] miss_count
);

  typedef enum logic [1:0] {TAG_NONE, TAG_PX, TAG_BG0, TAG_BG1} tag_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  tag_t       win;
  tag_t       tag;
  logic       rr;
  logic [7:0] wait_cnt0;
  logic [7:0] wait_cnt1;
  logic [7:0] px_hold;
  logic [7:0] bg_hold;
  logic       starve0;
  logic       starve1;

  assign starve0 = bus.bg_req[0] && (wait_cnt0 == LIMIT);
  assign starve1 = bus.bg_req[1] && (wait_cnt1 == LIMIT);

  // Reset forces idle so grants and rom_addr drop immediately.
  always_comb begin
    win = TAG_NONE;
    if (reset)                win = TAG_NONE;
    else if (starve0 && starve1) win = rr ? TAG_BG1 : TAG_BG0;
    else if (starve0)         win = TAG_BG0;
    else if (starve1)         win = TAG_BG1;
    else if (bus.px_req)      win = TAG_PX;
    else if (&bus.bg_req)     win = rr ? TAG_BG1 : TAG_BG0;
    else if (bus.bg_req[0])   win = TAG_BG0;
    else if (bus.bg_req[1])   win = TAG_BG1;
  end

  always_comb begin
    case (win)
      TAG_PX:  rom_addr = bus.px_addr;
      TAG_BG0: rom_addr = bus.bg_addr0;
      TAG_BG1: rom_addr = bus.bg_addr1;
      default: rom_addr = 11'h000;
    endcase
  end

  assign bus.bg_gnt   = {win == TAG_BG1, win == TAG_BG0};
  assign bus.px_valid = (tag == TAG_PX);
  assign bus.bg_valid = {tag == TAG_BG1, tag == TAG_BG0};
  assign bus.px_data  = (tag == TAG_PX) ? rom_data : px_hold;
  assign bus.bg_data  = (tag == TAG_BG0 || tag == TAG_BG1) ? rom_data : bg_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag         <= TAG_NONE;
      rr          <= 1'b0;
      wait_cnt0   <= 8'd0;
      wait_cnt1   <= 8'd0;
      px_hold     <= 8'd0;
      bg_hold     <= 8'd0;
      bus.px_miss <= 1'b0;
      miss_count  <= '0;
    end else begin
      tag         <= win;
      bus.px_miss <= bus.px_req && (win != TAG_PX);

      if (bus.px_miss && (miss_count != {MISS_W{1'b1}}))
        miss_count <= miss_count + MISS_W'(1);

      // Pointer parks on the client that did not just get served.
      if (win == TAG_BG0)      rr <= 1'b1;
      else if (win == TAG_BG1) rr <= 1'b0;

      if (!bus.bg_req[0] || win == TAG_BG0) wait_cnt0 <= 8'd0;
      else if (wait_cnt0 < LIMIT)           wait_cnt0 <= wait_cnt0 + 8'd1;

      if (!bus.bg_req[1] || win == TAG_BG1) wait_cnt1 <= 8'd0;
      else if (wait_cnt1 < LIMIT)           wait_cnt1 <= wait_cnt1 + 8'd1;

      if (tag == TAG_PX)                       px_hold <= rom_data;
      if (tag == TAG_BG0 || tag == TAG_BG1)    bg_hold <= rom_data;
    end
  end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM (11-bit address = {char 7b, row 4b}, 8-bit row word, 1-cycle read latency) between three requesters.
- Requester 0 is the real-time pixel text path (logo / initials overlay), which has priority.
- Requesters 1 and 2 are background clients (e.g. scoreboard/message line prefetchers that fill buffers during blanking); they are served round-robin.
- A starvation guard forces a background slot after STARVE_LIMIT waiting cycles, and reports every pixel-path miss.

Parameters:
- STARVE_LIMIT, 8: consecutive denied cycles after which a requesting background client pre-empts the pixel path (legal range 1..255).
- MISS_W, 16: width of the saturating pixel-miss counter.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  asynchronous, active-high reset.
- px_req  in  1  pixel path requests a ROM read this cycle.
- px_addr  in  11  pixel path ROM address.
- px_valid  out  1  px_data holds the word for the px_req granted in the previous cycle.
- px_miss  out  1  the px_req from the previous cycle was not granted.
- px_data  out  8  ROM word for the pixel path.
- bg_req  in  2  background requests; bit i belongs to client i.
- bg_addr0  in  11  client 0 address.
- bg_addr1  in  11  client 1 address.
- bg_gnt  out  2  one-hot grant, same cycle as the request (combinational).
- bg_valid  out  2  one-hot; bg_data is valid for that client (one cycle after its grant).
- bg_data  out  8  ROM word for background clients.
- rom_addr  out  11  address to font ROM.
- rom_data  in  8  ROM output, valid one cycle after rom_addr.
- miss_count  out  MISS_W  saturating count of px_miss pulses.

Behaviour:
- Reset (async, active-high): all outputs 0; rr pointer = client 0; wait counters = 0; return-tag register = none; miss_count = 0. Any in-flight read is discarded: no valid is asserted in the first cycle after reset release.
- Winner selection each cycle, in priority order:
  - (a) A background client with req=1 and wait==STARVE_LIMIT wins. If both qualify, the rr pointer decides.
  - (b) Otherwise, px_req wins.
  - (c) Otherwise, the requesting background client wins, chosen by round-robin starting at the rr pointer.
  - (d) Otherwise, idle.
- rom_addr = winner's address; 11'h000 when idle.
- bg_gnt[i] = 1 only in the cycle client i wins. No px grant output exists: the pixel path learns its outcome through px_valid/px_miss.
- Round-robin pointer: after any background grant (including a starvation grant), the pointer moves to the other client. It is unchanged on pixel-only or idle cycles.
- Return path: a registered 2-bit tag records the winner (none/px/bg0/bg1).
  - Cycle t+1: px_valid or bg_valid[i] = 1 according to the tag.
  - px_data and bg_data = rom_data when their valid is 1; otherwise they hold their last value.
  - Latency request-to-data is exactly 1 cycle; throughput is 1 read per cycle.
- px_miss: registered, = px_req at t AND winner at t ≠ px. It asserts only when a starvation grant displaced the pixel path.
- miss_count: +1 on each px_miss; saturates at 2^MISS_W−1 with no wrap.
- Wait counter i, 8 bits:
  - +1 per cycle while bg_req[i]=1 and bg_gnt[i]=0, saturating at STARVE_LIMIT.
  - Cleared on bg_gnt[i]=1, or on any cycle with bg_req[i]=0.
- Background protocol:
  - Client holds req and addr stable until it sees gnt.
  - Keeping req high after gnt requests the next read (back-to-back allowed).
  - Changing the address while waiting is permitted but undefined for verification; the bench keeps it stable.
- Simultaneous events:
  - px_req and both bg requests below limit: px wins, both wait counters increment.
  - px_req and a starved bg client: bg wins, px_miss pulses next cycle.
  - Both bg clients reach the limit in the same cycle: the pointer chooses; the loser stays at the limit and wins the following cycle.
- Reset mid-operation: counters, pointer and tag clear immediately; outputs drop to 0 asynchronously.

Test Plan:
1. px_req=1 with px_addr=11'h458 ('E' row 8), no bg requests → rom_addr=11'h458 same cycle; px_valid=1 next cycle; px_data=rom_data; px_miss=0.
2. bg_req=2'b11 held, px_req=0 → grants alternate bg_gnt=01,10,01,10 starting with client 0; bg_valid follows one cycle later each time.
3. px_req=1 continuous, bg_req=2'b01 held, STARVE_LIMIT=8 → bg_gnt[0]=1 in cycle 9 (wait reached 8); px_miss=1 in cycle 10; miss_count=1; pattern repeats every 9 cycles.
4. px_req=1 and both bg held from the same cycle → first forced grant goes to client 0, next cycle to client 1; two consecutive px_miss pulses; miss_count=2.
5. Assert reset while tag=bg1 in flight → bg_valid stays 0 after release; counters=0; first post-reset bg grant goes to client 0.
6. Preload miss_count to saturation (force or long run with MISS_W=4) → stays at 4'hF after further misses.
